// File: rtl/vector_normalize_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vector_normalize_arbiter
// Description : Round-robin, credit-based sharing of one fixed-latency,
//               non-stallable vector_normalize unit between NUM_REQ clients.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef FIXED_W
`define FIXED_W 16
`endif

module vector_normalize_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NORM_LATENCY = `FIXED_W + 1,
    parameter int RET_DEPTH    = 4,
    parameter int VEC_W        = 3 * `FIXED_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][VEC_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [NUM_REQ-1:0][VEC_W-1:0]   rsp_result,
    output logic [VEC_W-1:0]                norm_op,
    input  logic [VEC_W-1:0]                norm_result,
    output logic                            busy
);

    localparam int c_tag_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w = $clog2(RET_DEPTH) + 1;
    localparam int c_ptr_w = $clog2(RET_DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(RET_DEPTH);
    localparam logic [c_tag_w:0]   c_num_req = (c_tag_w + 1)'(NUM_REQ);
    localparam logic [c_tag_w-1:0] c_last    = c_tag_w'(NUM_REQ - 1);

    logic [c_tag_w-1:0]                   r_rr_ptr;
    logic [NUM_REQ-1:0][c_cnt_w-1:0]      w_inflight;
    logic [NUM_REQ-1:0][c_cnt_w-1:0]      w_count;
    logic [NUM_REQ-1:0][c_cnt_w-1:0]      w_credit;
    logic [NUM_REQ-1:0]                   w_elig;
    logic [NUM_REQ-1:0]                   w_grant;
    logic [NUM_REQ-1:0]                   w_push;
    logic [NUM_REQ-1:0]                   w_pop;
    logic                                 w_found;
    logic [c_tag_w-1:0]                   w_win;
    logic [c_tag_w-1:0]                   w_idx;
    logic [c_tag_w:0]                     w_sum;

    logic [VEC_W-1:0]                     r_norm_op;
    logic                                 r_iss_valid;
    logic [c_tag_w-1:0]                   r_iss_tag;
    logic [NORM_LATENCY-1:0]              r_dl_valid;
    logic [NORM_LATENCY-1:0][c_tag_w-1:0] r_dl_tag;
    logic                                 r_ret_valid;
    logic [c_tag_w-1:0]                   r_ret_tag;
    logic [VEC_W-1:0]                     r_ret_data;

    // Round-robin search starting at r_rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_tag_w + 1)'(k);
            w_idx = (w_sum >= c_num_req) ? c_tag_w'(w_sum - c_num_req) : c_tag_w'(w_sum);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (w_found && rst_n) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign norm_op   = r_norm_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_norm_op   <= '0;
            r_iss_valid <= 1'b0;
            r_iss_tag   <= '0;
        end else begin
            r_iss_valid <= w_found;
            r_iss_tag   <= w_win;
            r_norm_op   <= w_found ? req_op[w_win] : '0;
            if (w_found) begin
                r_rr_ptr <= (w_win == c_last) ? '0 : w_win + c_tag_w'(1);
            end
        end
    end

    // Owner tags ride alongside the unit's pipeline; a return register
    // then decouples the unit output from the FIFO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_valid  <= '0;
            r_dl_tag    <= '0;
            r_ret_valid <= 1'b0;
            r_ret_tag   <= '0;
            r_ret_data  <= '0;
        end else begin
            r_dl_valid[0] <= r_iss_valid;
            r_dl_tag[0]   <= r_iss_tag;
            for (int k = 1; k < NORM_LATENCY; k++) begin
                r_dl_valid[k] <= r_dl_valid[k-1];
                r_dl_tag[k]   <= r_dl_tag[k-1];
            end
            r_ret_valid <= r_dl_valid[NORM_LATENCY-1];
            r_ret_tag   <= r_dl_tag[NORM_LATENCY-1];
            r_ret_data  <= norm_result;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
            logic [c_cnt_w-1:0] r_inflight;
            logic [c_cnt_w-1:0] r_count;
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_ptr_w-1:0] r_rd_ptr;
            logic [VEC_W-1:0]   r_mem [RET_DEPTH];

            assign w_inflight[i] = r_inflight;
            assign w_count[i]    = r_count;
            assign w_credit[i]   = c_depth - r_count - r_inflight;
            assign w_elig[i]     = req_valid[i] && (w_credit[i] != '0);
            assign w_push[i]     = r_ret_valid && (r_ret_tag == c_tag_w'(i));
            assign w_pop[i]      = rsp_valid[i] && rsp_ready[i];
            assign rsp_valid[i]  = (r_count != '0);
            assign rsp_result[i] = r_mem[r_rd_ptr];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_inflight <= '0;
                    r_count    <= '0;
                    r_wr_ptr   <= '0;
                    r_rd_ptr   <= '0;
                end else begin
                    case ({w_grant[i], w_push[i]})
                        2'b10:   r_inflight <= r_inflight + c_cnt_w'(1);
                        2'b01:   r_inflight <= r_inflight - c_cnt_w'(1);
                        default: r_inflight <= r_inflight;
                    endcase
                    case ({w_push[i], w_pop[i]})
                        2'b10:   r_count <= r_count + c_cnt_w'(1);
                        2'b01:   r_count <= r_count - c_cnt_w'(1);
                        default: r_count <= r_count;
                    endcase
                    if (w_push[i]) begin
                        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                    end
                    if (w_pop[i]) begin
                        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                    end
                end
            end

            // Storage is deliberately not reset; r_count gates visibility.
            always_ff @(posedge clk) begin
                if (w_push[i]) begin
                    r_mem[r_wr_ptr] <= r_ret_data;
                end
            end

`ifndef SYNTHESIS
            a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                !(w_push[i] && !w_pop[i] && (r_count == c_depth)));
`endif
        end
    endgenerate

    assign busy = (|r_dl_valid) | (|w_inflight) | (|w_count);

endmodule

`default_nettype wire

// File: tb/tb_vector_normalize_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_normalize_arbiter
// Description : Scoreboard bench pairing the arbiter with a behavioural
//               fixed-latency normalizer model.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef FIXED_W
`define FIXED_W 16
`endif

module tb_vector_normalize_arbiter;

    localparam int NR    = 4;
    localparam int FW    = `FIXED_W;
    localparam int VW    = 3 * FW;
    localparam int NL    = FW + 1;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NR-1:0]          req_valid = '0;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][VW-1:0]  req_op = '0;
    logic [NR-1:0]          rsp_valid;
    logic [NR-1:0]          rsp_ready = '0;
    logic [NR-1:0][VW-1:0]  rsp_result;
    logic [VW-1:0]          norm_op;
    logic [VW-1:0]          norm_result;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int total [NR];
    int sent  [NR];
    logic [NR-1:0] hs = '0;
    logic [NR-1:0] last_hs = '0;
    logic [VW-1:0] sbq [NR][$];
    int grant_log[$];
    int gcyc_log[$];
    logic [VW-1:0] pipe [NL];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vector_normalize_arbiter #(
        .NUM_REQ      (NR),
        .NORM_LATENCY (NL),
        .RET_DEPTH    (DEPTH),
        .VEC_W        (VW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .norm_op     (norm_op),
        .norm_result (norm_result),
        .busy        (busy)
    );

    // Signed Q8.8 components, result truncated toward zero.
    function automatic logic [VW-1:0] norm_fn(input logic [VW-1:0] v);
        real c [3];
        real m;
        int s;
        logic [VW-1:0] r;
        for (int k = 0; k < 3; k++) begin
            s = int'($signed(v[k*FW +: FW]));
            c[k] = $itor(s) / 256.0;
        end
        m = $sqrt(c[0]*c[0] + c[1]*c[1] + c[2]*c[2]);
        r = '0;
        if (m > 0.0) begin
            for (int k = 0; k < 3; k++) begin
                s = $rtoi(c[k] / m * 256.0);
                r[k*FW +: FW] = FW'(s);
            end
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] gen_op(input int i, input int n);
        int x;
        int y;
        int z;
        x = 256 * (i + 1) + 37 * n;
        y = 200 - 50 * n;
        z = 13 * i - 90;
        return {FW'(x), FW'(y), FW'(z)};
    endfunction

    // Unreset normalizer model: NL-stage pipeline.
    always @(posedge clk) begin
        pipe[0] <= norm_fn(norm_op);
        for (int k = 1; k < NL; k++) pipe[k] <= pipe[k-1];
    end
    assign norm_result = pipe[NL-1];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard monitor, mid-cycle.
    always @(negedge clk) begin
        logic [VW-1:0] e;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) sbq[i].delete();
            hs = '0;
        end else begin
            check_eq("onehot", 64'($countones(req_ready) <= 1), 64'd1);
            hs = req_valid & req_ready;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    sbq[i].push_back(norm_fn(req_op[i]));
                    grant_log.push_back(i);
                    gcyc_log.push_back(cyc);
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (sbq[i].size() == 0) begin
                        check_eq("sb_empty", 64'(i), 64'hFFFF);
                    end else begin
                        e = sbq[i].pop_front();
                        check_eq("rsp_data", 64'(rsp_result[i]), 64'(e));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        last_hs = hs;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                sent[i]++;
                if (sent[i] < total[i]) req_op[i] = gen_op(i, sent[i]);
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic start_stream(input int i, input int n);
        total[i]     = n;
        sent[i]      = 0;
        req_op[i]    = gen_op(i, 0);
        req_valid[i] = (n > 0);
    endtask

    task automatic clear_streams();
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            total[i] = 0;
            sent[i]  = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rsp_ready = '0;
        clear_streams();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic bit pending();
        bit p;
        p = busy;
        for (int i = 0; i < NR; i++) begin
            if (sent[i] < total[i] || sbq[i].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while (pending() && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 64'(pending()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clear_streams();
        do_reset();

        // Reset state and single op latency
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_norm_op", 64'(norm_op), 64'd0);
        rsp_ready = '1;
        start_stream(0, 1);
        req_op[0] = 48'h0300_0000_0000;
        k = 0;
        do begin
            step();
            k++;
        end while (!last_hs[0] && k < 20);
        check_eq("t1_accept", 64'(last_hs[0]), 64'd1);
        k = 0;
        while (!rsp_valid[0] && k < 60) begin
            step();
            k++;
        end
        check_eq("t1_latency", 64'(k), 64'(NL + 2));
        check_eq("t1_result", 64'(rsp_result[0]), 64'h0000_0100_0000_0000);
        wait_drain("t1_drain", 100);
        check_eq("t1_busy", 64'(busy), 64'd0);

        // Full contention
        do_reset();
        rsp_ready = '1;
        grant_log.delete();
        gcyc_log.delete();
        for (int i = 0; i < NR; i++) start_stream(i, 4);
        wait_drain("t2_drain", 300);
        check_eq("t2_grants", 64'(grant_log.size()), 64'd16);
        if (grant_log.size() == 16) begin
            for (int j = 0; j < 16; j++) check_eq("t2_order", 64'(grant_log[j]), 64'(j % NR));
            check_eq("t2_span", 64'(gcyc_log[15] - gcyc_log[0]), 64'd15);
        end

        // Backpressure on requester 2
        do_reset();
        rsp_ready = 4'b1011;
        start_stream(2, 8);
        start_stream(0, 8);
        repeat (80) step();
        check_eq("t3_sent2", 64'(sent[2]), 64'd4);
        check_eq("t3_sent0", 64'(sent[0]), 64'd8);
        check_eq("t3_ready2", 64'(req_ready[2]), 64'd0);
        check_eq("t3_rspv2", 64'(rsp_valid[2]), 64'd1);
        rsp_ready[2] = 1'b1;
        step();
        rsp_ready[2] = 1'b0;
        repeat (40) step();
        check_eq("t3_one_more", 64'(sent[2]), 64'd5);
        check_eq("t3_ready2b", 64'(req_ready[2]), 64'd0);
        rsp_ready = '1;
        wait_drain("t3_drain", 300);
        check_eq("t3_sent2_all", 64'(sent[2]), 64'd8);

        // Full FIFO boundary on requester 1
        do_reset();
        rsp_ready = 4'b1101;
        start_stream(1, 5);
        repeat (40) step();
        check_eq("t4_sent_full", 64'(sent[1]), 64'd4);
        check_eq("t4_rspv1", 64'(rsp_valid[1]), 64'd1);
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready[1] = 1'b0;
        repeat (3) step();
        check_eq("t4_regrant", 64'(sent[1]), 64'd5);
        repeat (30) step();
        check_eq("t4_refull", 64'(rsp_valid[1]), 64'd1);
        check_eq("t4_ready1", 64'(req_ready[1]), 64'd0);
        rsp_ready = '1;
        wait_drain("t4_drain", 200);

        // Asynchronous reset with ops in flight and a queued result
        do_reset();
        rsp_ready = 4'b0111;
        start_stream(3, 1);
        repeat (25) step();
        check_eq("t5_pre_rspv3", 64'(rsp_valid[3]), 64'd1);
        start_stream(0, 1);
        start_stream(1, 1);
        start_stream(2, 1);
        repeat (4) step();
        check_eq("t5_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        clear_streams();
        #1;
        check_eq("t5_async_rspv", 64'(rsp_valid), 64'd0);
        check_eq("t5_async_busy", 64'(busy), 64'd0);
        check_eq("t5_async_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) step();
        check_eq("t5_no_stale", 64'(rsp_valid), 64'd0);
        check_eq("t5_idle_busy", 64'(busy), 64'd0);
        start_stream(3, 6);
        repeat (40) step();
        check_eq("t5_credits", 64'(sent[3]), 64'd4);
        rsp_ready = '1;
        wait_drain("t5_drain", 300);

        // Idle window, then confirm the RR pointer held
        start_stream(1, 1);
        wait_drain("t6_prep", 100);
        for (int j = 0; j < 50; j++) begin
            step();
            check_eq("t6_norm_op", 64'(norm_op), 64'd0);
            check_eq("t6_rspv", 64'(rsp_valid), 64'd0);
            check_eq("t6_busy", 64'(busy), 64'd0);
        end
        grant_log.delete();
        for (int i = 0; i < NR; i++) start_stream(i, 1);
        wait_drain("t6_drain", 100);
        check_eq("t6_grants", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            check_eq("t6_rr_first", 64'(grant_log[0]), 64'd2);
            check_eq("t6_rr_last", 64'(grant_log[3]), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
